// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - Coprocessor-0 register file with exception commit, timer and interrupt request
module cp0_regfile #(
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
  parameter int          COUNT_DIV    = 1  // must be >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        exc_commit,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_badv_we,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        int_req
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  // Status bits software may change: IM[15:8], EXL, IE; BEV is hard-wired to 1
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;

  logic [31:0]          badvaddr;
  logic [31:0]          count;
  logic [31:0]          compare;
  logic [COUNT_DIV-1:0] div;

  logic [31:0] status_next;
  logic [31:0] cause_next;
  logic        ti_next;
  logic        mtc0;

  // An exception commit in the same cycle squashes the MTC0 entirely
  assign mtc0 = we & ~exc_commit;

  // Next-state of Status and Cause, including timer flag and interrupt sampling
  always_comb begin
    status_next = status;
    cause_next  = cause;
    ti_next     = cause[30] | (count == compare);
    if (mtc0 && waddr == REG_COMPARE) begin
      ti_next = 1'b0;
    end
    if (mtc0 && waddr == REG_STATUS) begin
      status_next = (wdata & STATUS_WMASK) | STATUS_BEV;
    end
    if (exc_commit) begin
      status_next[1] = 1'b1;
    end else if (eret) begin
      status_next[1] = 1'b0;
    end
    cause_next[30]    = ti_next;
    cause_next[15:10] = {hw_int[5] | ti_next, hw_int[4:0]};
    if (mtc0 && waddr == REG_CAUSE) begin
      cause_next[9:8] = wdata[9:8];
    end
    if (exc_commit) begin
      cause_next[6:2] = exc_code;
      if (!status[1]) begin
        cause_next[31] = exc_bd;
      end
    end
  end

  // Register state update; exception commit takes priority over MTC0 for EPC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status   <= STATUS_RESET;
      cause    <= 32'd0;
      epc      <= 32'd0;
      badvaddr <= 32'd0;
      count    <= 32'd0;
      compare  <= 32'd0;
      div      <= '0;
    end else begin
      status <= status_next;
      cause  <= cause_next;
      div    <= div + COUNT_DIV'(1);
      if (mtc0 && waddr == REG_COUNT) begin
        count <= wdata;
      end else if (&div) begin
        count <= count + 32'd1;
      end
      if (mtc0 && waddr == REG_COMPARE) begin
        compare <= wdata;
      end
      if (exc_commit) begin
        if (!status[1]) begin
          epc <= exc_pc;
        end
      end else if (mtc0 && waddr == REG_EPC) begin
        epc <= wdata;
      end
      if (exc_commit && exc_badv_we) begin
        badvaddr <= exc_badvaddr;
      end
    end
  end

  // MFC0 read mux; shows registered values, no write bypass
  always_comb begin
    rdata = 32'd0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr;
      REG_COUNT:    rdata = count;
      REG_COMPARE:  rdata = compare;
      REG_STATUS:   rdata = status;
      REG_CAUSE:    rdata = cause;
      REG_EPC:      rdata = epc;
      default:      rdata = 32'd0;
    endcase
  end

  assign int_req = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));

endmodule
